// File: rtl/alu_pkg.sv
// alu_pkg: ALU command encoding and sequencer state shared by the ALU
// wrapper blocks.
package alu_pkg;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} seq_state_e;

    // Only add/sub produce meaningful carry and overflow.
    function automatic logic has_flags(input logic [2:0] cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction
endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter: loadable down-counter that stops at zero and flags it.
module alu_settle_counter #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("SETTLE must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? CW'(SETTLE - 1) : ((cnt_q != '0) ? cnt_q - CW'(1) : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: registers requests into a combinational ALU, waits a settle
// window, captures result/flags and hands them downstream via valid/ready.
module alu_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);
    import alu_pkg::*;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             accept, settle_done;

    alu_settle_counter #(.SETTLE(SETTLE)) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .done  (settle_done)
    );

    always_comb begin
        req_ready  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        accept     = req_ready && req_valid;
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        cmd_d      = cmd_q;
        result_d   = result_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;
        if ((state_q == alu_pkg::SETTLE) && settle_done) begin
            result_d = alu_result;
            carry_d  = has_flags(cmd_q) && alu_carryout;
            ovf_d    = has_flags(cmd_q) && alu_overflow;
            zero_d   = (alu_result == '0);
            state_d  = RESP;
        end
        if ((state_q == RESP) && rsp_ready) begin
            op_count_d = op_count_q + CNT_W'(1);
            state_d    = IDLE;
        end
        // A response handed off in the same cycle may be replaced immediately.
        if (accept) begin
            alu_a_d = req_a;
            alu_b_d = req_b;
            cmd_d   = req_cmd;
            state_d = alu_pkg::SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            cmd_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            cmd_q      <= cmd_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            op_count_q <= op_count_d;
        end
    end

    assign alu_operandA = alu_a_q;
    assign alu_operandB = alu_b_q;
    assign alu_command  = cmd_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_result   = result_q;
    assign rsp_carryout = carry_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign op_count     = op_count_q;
endmodule
